// File: rtl/pair_uart_tx_if.sv
// Pair handshake between the pair-memory walker (master) and pair_uart_tx (slave).
// A pair transfers on a posedge where pair_valid && pair_ready; valid may drop with no transfer.
interface pair_uart_tx_if;
    logic       pair_valid;
    logic       pair_ready;
    logic [7:0] pair_lhs;
    logic [7:0] pair_rhs;
    logic       pair_last;

    modport master (output pair_valid, pair_lhs, pair_rhs, pair_last, input pair_ready);
    modport slave  (input pair_valid, pair_lhs, pair_rhs, pair_last, output pair_ready);
endinterface

// File: rtl/pair_uart_tx.sv
// pair_uart_tx: FIFO of (lhs, rhs) pairs serialised as UART 8N1 frames, lhs first then rhs.
// Define PAIR_UART_CRLF_EN to append CR, LF after the rhs byte of a pair flagged last.
module pair_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    pair_uart_tx_if.slave               pair,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [1:0]                  state_dbg,    // 0 IDLE, 1 START, 2 DATA, 3 STOP
    output logic                        line_end_dbg  // last flag of the pair in flight
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
`ifdef PAIR_UART_CRLF_EN
    localparam int SEL_W = 2;
`else
    localparam int SEL_W = 1;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [16:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level;
    logic              push;
    logic              pop;
    logic [16:0]       head;
    logic [TW-1:0]     timer;
    logic [7:0]        shift;
    logic [2:0]        bit_cnt;
    logic [7:0]        hold_rhs;
    logic              hold_last;
    logic [SEL_W-1:0]  sel;

    assign pair.pair_ready = (level != (AW+1)'(FIFO_DEPTH));
    assign push            = pair.pair_valid && pair.pair_ready;
    assign pop             = (state == IDLE) && (level != '0);
    assign head            = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pair.pair_last, pair.pair_lhs, pair.pair_rhs};
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            timer     <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            hold_rhs  <= '0;
            hold_last <= 1'b0;
            sel       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift     <= head[15:8];
                        hold_rhs  <= head[7:0];
                        hold_last <= head[16];
                        sel       <= '0;
                        tx        <= 1'b0;
                        timer     <= BIT_LAST;
                        state     <= START;
                    end
                end
                START: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        tx      <= shift[0];
                        timer   <= BIT_LAST;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        timer <= BIT_LAST;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        timer <= BIT_LAST;
                        // Next byte of the sequence starts straight out of the stop bit.
                        if (sel == '0) begin
                            shift <= hold_rhs;
                            sel   <= SEL_W'(1);
                            tx    <= 1'b0;
                            state <= START;
                        end
`ifdef PAIR_UART_CRLF_EN
                        else if (sel == 2'd1 && hold_last) begin
                            shift <= 8'h0D;
                            sel   <= 2'd2;
                            tx    <= 1'b0;
                            state <= START;
                        end else if (sel == 2'd2) begin
                            shift <= 8'h0A;
                            sel   <= 2'd3;
                            tx    <= 1'b0;
                            state <= START;
                        end
`endif
                        else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = (state != IDLE) || (level != '0);
    assign fifo_level   = level;
    assign state_dbg    = state;
    assign line_end_dbg = hold_last;
endmodule
